// File: rtl/crosshair_overlay_pkg.sv
// Shared types and widths for the crosshair overlay path.
// Holds the frame-tracking state enum, pixel/count widths and an abs helper.
package crosshair_overlay_pkg;

    localparam int RGB_W = 24;
    localparam int H_W   = 11;
    localparam int V_W   = 10;
    localparam int D_W   = 12;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRACKING = 2'd1,
        STALE    = 2'd2
    } state_t;

    // Magnitude of a signed offset; the result always fits in D_W bits
    // because offsets never reach the most negative value.
    function automatic logic [D_W-1:0] abs_d(input logic signed [D_W-1:0] v);
        return v[D_W-1] ? D_W'(-v) : D_W'(v);
    endfunction

endpackage

// File: rtl/crosshair_hit.sv
// Two-stage hit-test datapath: stage 1 registers |dx|, |dy|, pixel, valid
// and marker enable; stage 2 compares against the arm box and muxes COLOR.
// Ports: clk_in, rst_in, hcount_in, vcount_in, cx_in, cy_in, en_in,
//        pixel_in, data_valid_in -> pixel_out, valid_out.
module crosshair_hit
    import crosshair_overlay_pkg::*;
#(
    parameter int               ARM   = 16,
    parameter int               THICK = 1,
    parameter logic [RGB_W-1:0] COLOR = 24'hFF0000
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [H_W-1:0]   hcount_in,
    input  logic [V_W-1:0]   vcount_in,
    input  logic [H_W-1:0]   cx_in,
    input  logic [V_W-1:0]   cy_in,
    input  logic             en_in,
    input  logic [RGB_W-1:0] pixel_in,
    input  logic             data_valid_in,
    output logic [RGB_W-1:0] pixel_out,
    output logic             valid_out
);

    localparam logic [D_W-1:0] ARM_V   = D_W'(ARM);
    localparam logic [D_W-1:0] THICK_V = D_W'(THICK);

    // Zero-extended before subtracting, so offsets are true signed
    // distances and a centroid near an edge never wraps around.
    logic signed [D_W-1:0] dx;
    logic signed [D_W-1:0] dy;

    assign dx = $signed({1'b0, hcount_in} - {1'b0, cx_in});
    assign dy = $signed({2'b00, vcount_in} - {2'b00, cy_in});

    logic [D_W-1:0]   adx_q;
    logic [D_W-1:0]   ady_q;
    logic [RGB_W-1:0] pix_q;
    logic             vld_q;
    logic             en_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            adx_q <= '0;
            ady_q <= '0;
            pix_q <= '0;
            vld_q <= 1'b0;
            en_q  <= 1'b0;
        end else begin
            adx_q <= abs_d(dx);
            ady_q <= abs_d(dy);
            pix_q <= pixel_in;
            vld_q <= data_valid_in;
            en_q  <= en_in;
        end
    end

    logic hit;

    assign hit = ((adx_q <= ARM_V) && (ady_q <= THICK_V)) ||
                 ((ady_q <= ARM_V) && (adx_q <= THICK_V));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pixel_out <= '0;
            valid_out <= 1'b0;
        end else begin
            pixel_out <= (hit && en_q) ? COLOR : pix_q;
            valid_out <= vld_q;
        end
    end

endmodule

// File: rtl/crosshair_overlay.sv
// Crosshair overlay: latches centroids frame-synchronously, tracks staleness
// and blinks the marker when stale, then composites it over pixel_in.
// Ports: clk_in, rst_in, x_in/y_in/valid_in (centroid), hcount_in,
//        vcount_in, data_valid_in, new_frame_in, pixel_in -> pixel_out,
//        valid_out, marker_active_out.
module crosshair_overlay
    import crosshair_overlay_pkg::*;
#(
    parameter int               ARM          = 16,
    parameter int               THICK        = 1,
    parameter logic [RGB_W-1:0] COLOR        = 24'hFF0000,
    parameter int               STALE_FRAMES = 30,
    parameter int               BLINK_HALF   = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [H_W-1:0]   x_in,
    input  logic [V_W-1:0]   y_in,
    input  logic             valid_in,
    input  logic [H_W-1:0]   hcount_in,
    input  logic [V_W-1:0]   vcount_in,
    input  logic             data_valid_in,
    input  logic             new_frame_in,
    input  logic [RGB_W-1:0] pixel_in,
    output logic [RGB_W-1:0] pixel_out,
    output logic             valid_out,
    output logic             marker_active_out
);

    localparam int SW = $clog2(STALE_FRAMES + 1);
    localparam int BW = (2 * BLINK_HALF > 1) ? $clog2(2 * BLINK_HALF) : 1;

    localparam logic [SW-1:0] STALE_MAX  = SW'(STALE_FRAMES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_HALF - 1);
    localparam logic [BW-1:0] BLINK_ON   = BW'(BLINK_HALF);

    logic [H_W-1:0] sx;
    logic [V_W-1:0] sy;
    logic           pending;
    logic [H_W-1:0] cx;
    logic [V_W-1:0] cy;

    // A centroid arriving together with new_frame_in skips the shadow.
    logic load;

    assign load = new_frame_in && (pending || valid_in);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sx      <= '0;
            sy      <= '0;
            pending <= 1'b0;
        end else if (new_frame_in) begin
            pending <= 1'b0;
        end else if (valid_in) begin
            sx      <= x_in;
            sy      <= y_in;
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cx <= '0;
            cy <= '0;
        end else if (load) begin
            cx <= valid_in ? x_in : sx;
            cy <= valid_in ? y_in : sy;
        end
    end

    state_t        state_q;
    state_t        state_d;
    logic [SW-1:0] stale_q;
    logic [SW-1:0] stale_d;
    logic [BW-1:0] blink_q;
    logic [BW-1:0] blink_d;
    logic          active_d;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q           <= IDLE;
            stale_q           <= '0;
            blink_q           <= '0;
            marker_active_out <= 1'b0;
        end else begin
            state_q           <= state_d;
            stale_q           <= stale_d;
            blink_q           <= blink_d;
            marker_active_out <= active_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        stale_d  = stale_q;
        blink_d  = blink_q;
        active_d = marker_active_out;
        if (new_frame_in) begin
            if (load) begin
                stale_d = '0;
            end else if (stale_q != STALE_MAX) begin
                stale_d = stale_q + 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (load) state_d = TRACKING;
                end
                TRACKING: begin
                    if (!load && stale_d == STALE_MAX) begin
                        state_d = STALE;
                        blink_d = '0;
                    end
                end
                STALE: begin
                    if (load) begin
                        state_d = TRACKING;
                    end else begin
                        blink_d = (blink_q == BLINK_LAST) ? '0 : blink_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            // Marker visibility is decided once per frame, from the state
            // the frame will run in.
            active_d = (state_d == TRACKING) ||
                       ((state_d == STALE) && (blink_d < BLINK_ON));
        end
    end

    crosshair_hit #(
        .ARM   (ARM),
        .THICK (THICK),
        .COLOR (COLOR)
    ) u_hit (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .cx_in         (cx),
        .cy_in         (cy),
        .en_in         (marker_active_out),
        .pixel_in      (pixel_in),
        .data_valid_in (data_valid_in),
        .pixel_out     (pixel_out),
        .valid_out     (valid_out)
    );

endmodule

// File: tb/tb_crosshair_overlay.sv
// Scoreboard bench for crosshair_overlay: randomized pixels checked against
// a frame-counting reference model; a negedge monitor pops and compares.
module tb_crosshair_overlay;

    localparam int          ARM   = 16;
    localparam int          THICK = 1;
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam int          STALE = 30;
    localparam int          HALF  = 8;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [10:0] x_in = '0;
    logic [9:0]  y_in = '0;
    logic        valid_in = 1'b0;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        data_valid_in = 1'b0;
    logic        new_frame_in = 1'b0;
    logic [23:0] pixel_in = '0;
    logic [23:0] pixel_out;
    logic        valid_out;
    logic        marker_active_out;

    crosshair_overlay dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .x_in              (x_in),
        .y_in              (y_in),
        .valid_in          (valid_in),
        .hcount_in         (hcount_in),
        .vcount_in         (vcount_in),
        .data_valid_in     (data_valid_in),
        .new_frame_in      (new_frame_in),
        .pixel_in          (pixel_in),
        .pixel_out         (pixel_out),
        .valid_out         (valid_out),
        .marker_active_out (marker_active_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q[$];

    // Reference model: frames since the last centroid load decide visibility.
    int m_sx, m_sy, m_cx, m_cy;
    bit m_pend, m_ever, m_active;
    int m_fs;

    task automatic model_reset();
        m_sx = 0; m_sy = 0; m_cx = 0; m_cy = 0;
        m_pend = 0; m_ever = 0; m_active = 0; m_fs = 0;
    endtask

    function automatic bit model_hit(int h, int v);
        int adx, ady;
        adx = (h > m_cx) ? h - m_cx : m_cx - h;
        ady = (v > m_cy) ? v - m_cy : m_cy - v;
        return (adx <= ARM && ady <= THICK) || (ady <= ARM && adx <= THICK);
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic centroid(int x, int y);
        data_valid_in = 1'b0;
        valid_in = 1'b1;
        x_in = 11'(x);
        y_in = 10'(y);
        m_sx = x; m_sy = y; m_pend = 1;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic frame(bit v, int x, int y);
        bit ld;
        data_valid_in = 1'b0;
        new_frame_in = 1'b1;
        valid_in = v;
        x_in = 11'(x);
        y_in = 10'(y);
        ld = v || m_pend;
        if (v) begin
            m_cx = x; m_cy = y;
        end else if (m_pend) begin
            m_cx = m_sx; m_cy = m_sy;
        end
        m_pend = 0;
        if (ld) begin
            m_ever = 1; m_fs = 0;
        end else begin
            m_fs++;
        end
        if (!m_ever) m_active = 0;
        else if (m_fs < STALE) m_active = 1;
        else m_active = ((m_fs - STALE) % (2 * HALF)) < HALF;
        tick();
        new_frame_in = 1'b0;
        valid_in = 1'b0;
        check("marker_active", 32'(marker_active_out), 32'(m_active));
    endtask

    task automatic pixel(int h, int v, logic [23:0] p, bit dv);
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        pixel_in = p;
        data_valid_in = dv;
        if (dv) exp_q.push_back((m_active && model_hit(h, v)) ? RED : p);
        tick();
        data_valid_in = 1'b0;
    endtask

    task automatic rand_pixels(int n);
        int h, v;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                h = m_cx + int'($urandom_range(0, 40)) - 20;
                v = m_cy + int'($urandom_range(0, 40)) - 20;
            end else begin
                h = int'($urandom_range(0, 2047));
                v = int'($urandom_range(0, 1023));
            end
            if (h < 0) h = 0;
            if (h > 2047) h = 2047;
            if (v < 0) v = 0;
            if (v > 1023) v = 1023;
            pixel(h, v, 24'($urandom), $urandom_range(0, 4) != 0);
        end
    endtask

    // Monitor: valid_out must trail data_valid_in by two cycles, and each
    // valid output pixel is compared with the oldest expected value.
    bit h1 = 0, h2 = 0;
    logic [23:0] e;

    always @(negedge clk_in) begin
        if (rst_in) begin
            h1 = 0;
            h2 = 0;
        end else begin
            checks++;
            if (valid_out !== h2) begin
                errors++;
                $display("FAIL valid_delay got %b want %b", valid_out, h2);
            end
            h2 = h1;
            h1 = data_valid_in;
            if (valid_out === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pixel_unexpected got %h want none", pixel_out);
                end else begin
                    e = exp_q.pop_front();
                    if (pixel_out !== e) begin
                        errors++;
                        $display("FAIL pixel got %h want %h", pixel_out, e);
                    end
                end
            end
        end
    end

    initial begin
        model_reset();
        rst_in = 1'b1;
        #1;
        check("rst_pixel", 32'(pixel_out), 32'h0);
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_active", 32'(marker_active_out), 32'h0);
        tick();
        tick();
        rst_in = 1'b0;
        tick();

        // No centroid ever: pass-through.
        for (int f = 0; f < 3; f++) begin
            frame(0, 0, 0);
            for (int i = 0; i < 8; i++)
                pixel(int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)),
                      24'h123456, 1'b1);
            pixel(0, 0, 24'h123456, 1'b1);
        end

        // Basic arm geometry.
        centroid(200, 300);
        frame(0, 0, 0);
        pixel(200, 300, 24'h0000AA, 1'b1);
        pixel(216, 300, 24'h0000AA, 1'b1);
        pixel(200, 284, 24'h0000AA, 1'b1);
        pixel(217, 300, 24'h0000AA, 1'b1);
        pixel(202, 302, 24'h0000AA, 1'b1);
        rand_pixels(20);

        // Mid-frame update must not move the current marker.
        centroid(100, 100);
        pixel(200, 300, 24'h00BB00, 1'b1);
        pixel(100, 100, 24'h00BB00, 1'b1);
        rand_pixels(10);
        frame(0, 0, 0);
        pixel(100, 100, 24'h00BB00, 1'b1);
        pixel(200, 300, 24'h00BB00, 1'b1);
        rand_pixels(10);

        // Update coincident with the frame pulse bypasses the shadow.
        frame(1, 50, 60);
        pixel(50, 60, 24'h111111, 1'b1);
        pixel(66, 60, 24'h111111, 1'b1);
        rand_pixels(10);

        // Edge clipping, no wrap.
        centroid(5, 3);
        frame(0, 0, 0);
        pixel(0, 3, 24'h222222, 1'b1);
        pixel(5, 0, 24'h222222, 1'b1);
        pixel(2047, 3, 24'h222222, 1'b1);
        pixel(2047, 0, 24'h222222, 1'b1);
        pixel(5, 1023, 24'h222222, 1'b1);
        rand_pixels(10);

        // Staleness and blinking.
        centroid(400, 200);
        frame(0, 0, 0);
        for (int f = 1; f <= 50; f++) begin
            frame(0, 0, 0);
            pixel(400, 200, 24'h333333, 1'b1);
            rand_pixels(2);
        end
        centroid(300, 400);
        frame(0, 0, 0);
        pixel(300, 400, 24'h444444, 1'b1);
        rand_pixels(10);

        // Reset mid-frame discards the pipeline.
        pixel(300, 400, 24'h555555, 1'b1);
        pixel(301, 400, 24'h555555, 1'b1);
        rst_in = 1'b1;
        #1;
        exp_q.delete();
        model_reset();
        check("midrst_pixel", 32'(pixel_out), 32'h0);
        check("midrst_valid", 32'(valid_out), 32'h0);
        check("midrst_active", 32'(marker_active_out), 32'h0);
        tick();
        rst_in = 1'b0;
        tick();
        frame(0, 0, 0);
        pixel(300, 400, 24'h666666, 1'b1);
        rand_pixels(5);

        for (int i = 0; i < 4; i++) tick();
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
